// File: rtl/cla_serial_adder.sv
// ---------------------------------------------------------------------------
// cla_serial_adder
//
// Multi-cycle WIDTH-bit adder built around a single 4-bit carry-lookahead
// slice. Operands are captured on a start handshake and one 4-bit group is
// processed per clock, least-significant group first. The carry between
// groups is held in a register, so there is no lookahead across groups.
//
// Parameters:
//   WIDTH  operand/result width, a multiple of 4 and at least 4
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only while ready=1
//   a      in   operand A, captured on the accepting edge
//   b      in   operand B, captured on the accepting edge
//   ci     in   carry-in, captured on the accepting edge
//   ready  out  high only in IDLE
//   done   out  one-cycle pulse, result valid
//   sum    out  registered result
//   co     out  registered carry-out of bit WIDTH-1
//   ovf    out  registered signed overflow (carry into MSB xor carry-out)
// ---------------------------------------------------------------------------
module cla_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [IW-1:0] LAST_GROUP = IW'(N - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic             carry_q, carry_d;
    logic [IW-1:0]    index_q, index_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;

    logic [3:0] grpA;
    logic [3:0] grpB;
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;
    logic [3:0] grpSum;

    // Select the operand nibbles of the group currently pointed to by the
    // index register. A constant-bounded loop keeps the mux free of
    // variable part-selects and width casts.
    always_comb begin
        grpA = '0;
        grpB = '0;
        for (int k = 0; k < N; k++) begin
            if (index_q == IW'(k)) begin
                grpA = opA_q[4*k +: 4];
                grpB = opB_q[4*k +: 4];
            end
        end
    end

    // Two-level lookahead for the selected group. Every carry is written
    // directly in terms of propagate/generate and the registered group
    // carry-in, so no carry ripples through the slice.
    always_comb begin
        p = grpA ^ grpB;
        g = grpA & grpB;
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        grpSum = p ^ c[3:0];
    end

    // Sequencer and datapath next-state. An accepted request clears the
    // visible result so unprocessed groups read zero while running. The
    // last group also produces carry-out and signed overflow, and the index
    // stops at the last group instead of wrapping.
    always_comb begin
        state_d = state_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        carry_d = carry_q;
        index_d = index_q;
        sum_d   = sum_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    opA_d   = a;
                    opB_d   = b;
                    carry_d = ci;
                    index_d = '0;
                    sum_d   = '0;
                    co_d    = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int k = 0; k < N; k++) begin
                    if (index_q == IW'(k)) begin
                        sum_d[4*k +: 4] = grpSum;
                    end
                end
                carry_d = c[4];
                if (index_q == LAST_GROUP) begin
                    co_d    = c[4];
                    ovf_d   = c[3] ^ c[4];
                    state_d = DONE;
                end else begin
                    index_d = index_q + IW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset discards any operation in flight,
    // including a partially built sum, and returns to the idle values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opA_q   <= '0;
            opB_q   <= '0;
            carry_q <= 1'b0;
            index_q <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            carry_q <= carry_d;
            index_q <= index_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake flags are decoded straight from the state register, and the
    // result outputs come directly from their registers.
    always_comb begin
        ready = (state_q == IDLE);
        done  = (state_q == DONE);
        sum   = sum_q;
        co    = co_q;
        ovf   = ovf_q;
    end

endmodule
